// File: rtl/raster_pkg.sv
// Shared constants, capture-word layout, FSM states and octant codes for the
// line rasterizer control path.
package raster_pkg;

  localparam int COORD_W = 10;
  localparam int ATTR_W  = 6;
  localparam int CAP_W   = 4 * COORD_W + ATTR_W;
  localparam int ERR_W   = COORD_W + 2;

  // Capture word is {x0, y0, x1, y1, attr}, MSB first
  localparam int X0_LSB   = 3 * COORD_W + ATTR_W;
  localparam int Y0_LSB   = 2 * COORD_W + ATTR_W;
  localparam int X1_LSB   = COORD_W + ATTR_W;
  localparam int Y1_LSB   = ATTR_W;
  localparam int ATTR_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_DRAW  = 2'd2
  } state_t;

  localparam logic [1:0] OCT_X_SAME = 2'b01;
  localparam logic [1:0] OCT_Y_SAME = 2'b00;
  localparam logic [1:0] OCT_X_OPP  = 2'b10;
  localparam logic [1:0] OCT_Y_OPP  = 2'b11;

  // polarity = sign(dx) xor sign(dy); steep = y-major
  function automatic logic [1:0] octant_code(input logic polarity, input logic steep);
    logic [1:0] code;
    case ({polarity, steep})
      2'b00:   code = OCT_X_SAME;
      2'b01:   code = OCT_Y_SAME;
      2'b10:   code = OCT_X_OPP;
      default: code = OCT_Y_OPP;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/line_setup.sv
// Combinational line setup: unpacks the capture word and derives deltas,
// major/minor lengths, step directions, steep flag and octant.
module line_setup
  import raster_pkg::*;
(
  input  logic [CAP_W-1:0]   cap_word,
  output logic [COORD_W-1:0] x0,
  output logic [COORD_W-1:0] y0,
  output logic [ATTR_W-1:0]  attr,
  output logic [COORD_W-1:0] major,
  output logic [COORD_W-1:0] minor,
  output logic               steep,
  output logic [1:0]         sx,
  output logic [1:0]         sy,
  output logic [1:0]         octant
);

  logic [COORD_W-1:0] x1, y1;
  logic [COORD_W:0]   dx, dy;
  logic [COORD_W-1:0] adx, ady;

  assign x0   = cap_word[X0_LSB +: COORD_W];
  assign y0   = cap_word[Y0_LSB +: COORD_W];
  assign x1   = cap_word[X1_LSB +: COORD_W];
  assign y1   = cap_word[Y1_LSB +: COORD_W];
  assign attr = cap_word[ATTR_LSB +: ATTR_W];

  // 11-bit two's complement deltas; magnitudes always fit in COORD_W bits
  assign dx = {1'b0, x1} - {1'b0, x0};
  assign dy = {1'b0, y1} - {1'b0, y0};

  assign adx = dx[COORD_W] ? COORD_W'(~dx + 1'b1) : COORD_W'(dx);
  assign ady = dy[COORD_W] ? COORD_W'(~dy + 1'b1) : COORD_W'(dy);

  assign steep = (ady > adx);
  assign major = steep ? ady : adx;
  assign minor = steep ? adx : ady;

  // Step encoding: 01 = +1, 11 = -1, 00 = no step (sign-extends into an adder)
  assign sx = (dx == '0) ? 2'b00 : (dx[COORD_W] ? 2'b11 : 2'b01);
  assign sy = (dy == '0) ? 2'b00 : (dy[COORD_W] ? 2'b11 : 2'b01);

  assign octant = octant_code(dx[COORD_W] ^ dy[COORD_W], steep);

endmodule

// File: rtl/line_raster_ctrl.sv
// Line rasterizer controller: accepts one line, runs a one-cycle setup, then
// emits Bresenham pixels under valid/ready until the endpoint is handed off.
module line_raster_ctrl
  import raster_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               line_valid,
  output logic               line_ready,
  input  logic [CAP_W-1:0]   line_cap_reg,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [ATTR_W-1:0]  pix_attr,
  output logic               pix_last,
  output logic [1:0]         line_octant,
  output logic               busy
);

  state_t state;

  logic [CAP_W-1:0]   cap_q;
  logic [COORD_W-1:0] s_x0, s_y0, s_major, s_minor;
  logic [ATTR_W-1:0]  s_attr;
  logic               s_steep;
  logic [1:0]         s_sx, s_sy, s_octant;

  logic                    steep_q;
  logic [1:0]              sx_q, sy_q;
  logic [COORD_W-1:0]      major_q, minor_q, count_q;
  logic signed [ERR_W-1:0] err_q;

  logic signed [ERR_W-1:0] err_sub, err_next;
  logic                    minor_step, step_x, step_y;
  logic [COORD_W-1:0]      x_next, y_next;

  line_setup u_setup (
    .cap_word (cap_q),
    .x0       (s_x0),
    .y0       (s_y0),
    .attr     (s_attr),
    .major    (s_major),
    .minor    (s_minor),
    .steep    (s_steep),
    .sx       (s_sx),
    .sy       (s_sy),
    .octant   (s_octant)
  );

  assign line_ready = (state == ST_IDLE);
  assign busy       = (state != ST_IDLE);

  // Next Bresenham position; the minor axis moves only when err goes negative
  always_comb begin
    err_sub    = err_q - $signed({2'b00, minor_q});
    minor_step = err_sub[ERR_W-1];
    err_next   = err_sub;
    if (minor_step) begin
      err_next = err_sub + $signed({2'b00, major_q});
    end
    step_x = steep_q ? minor_step : 1'b1;
    step_y = steep_q ? 1'b1 : minor_step;
    x_next = pix_x;
    y_next = pix_y;
    if (step_x) begin
      x_next = pix_x + {{(COORD_W-1){sx_q[1]}}, sx_q[0]};
    end
    if (step_y) begin
      y_next = pix_y + {{(COORD_W-1){sy_q[1]}}, sy_q[0]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      cap_q       <= '0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_attr    <= '0;
      pix_last    <= 1'b0;
      line_octant <= '0;
      steep_q     <= 1'b0;
      sx_q        <= '0;
      sy_q        <= '0;
      major_q     <= '0;
      minor_q     <= '0;
      count_q     <= '0;
      err_q       <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (line_valid) begin
            cap_q <= line_cap_reg;
            state <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          pix_valid   <= 1'b1;
          pix_x       <= s_x0;
          pix_y       <= s_y0;
          pix_attr    <= s_attr;
          pix_last    <= (s_major == '0);
          line_octant <= s_octant;
          steep_q     <= s_steep;
          sx_q        <= s_sx;
          sy_q        <= s_sy;
          major_q     <= s_major;
          minor_q     <= s_minor;
          count_q     <= s_major;
          err_q       <= $signed({2'b00, s_major >> 1});
          state       <= ST_DRAW;
        end
        ST_DRAW: begin
          // Outputs hold while the pixel stage stalls
          if (pix_ready) begin
            if (count_q == '0) begin
              pix_valid <= 1'b0;
              pix_last  <= 1'b0;
              state     <= ST_IDLE;
            end else begin
              pix_x    <= x_next;
              pix_y    <= y_next;
              err_q    <= err_next;
              count_q  <= count_q - 1'b1;
              pix_last <= (count_q == COORD_W'(1));
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          pix_valid <= 1'b0;
          pix_last  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_raster_ctrl.sv
// Directed bench for line_raster_ctrl: a table of lines with hand-computed
// pixel sequences, plus reset-state and mid-line reset sequences.
module tb_line_raster_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_valid;
  logic        line_ready;
  logic [45:0] line_cap_reg;
  logic        pix_valid;
  logic        pix_ready;
  logic [9:0]  pix_x;
  logic [9:0]  pix_y;
  logic [5:0]  pix_attr;
  logic        pix_last;
  logic [1:0]  line_octant;
  logic        busy;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct {
    logic [9:0] x0, y0, x1, y1;
    logic [5:0] attr;
    logic [1:0] oct;
    int         stall_at;
    int         base;
    int         npix;
  } line_vec_t;

  line_vec_t  lines[$];
  logic [9:0] exp_x[$];
  logic [9:0] exp_y[$];

  line_raster_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .line_valid   (line_valid),
    .line_ready   (line_ready),
    .line_cap_reg (line_cap_reg),
    .pix_valid    (pix_valid),
    .pix_ready    (pix_ready),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_attr     (pix_attr),
    .pix_last     (pix_last),
    .line_octant  (line_octant),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int unsigned actual, input int unsigned expected);
    checks_total++;
    if (actual == expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  function automatic void addLine(input int x0, input int y0, input int x1, input int y1,
                                  input int attr, input int oct, input int stall_at);
    line_vec_t v;
    v.x0 = 10'(x0); v.y0 = 10'(y0); v.x1 = 10'(x1); v.y1 = 10'(y1);
    v.attr = 6'(attr); v.oct = 2'(oct); v.stall_at = stall_at;
    v.base = exp_x.size(); v.npix = 0;
    lines.push_back(v);
  endfunction

  function automatic void addPix(input int x, input int y);
    int idx;
    idx = lines.size() - 1;
    exp_x.push_back(10'(x));
    exp_y.push_back(10'(y));
    lines[idx].npix = lines[idx].npix + 1;
  endfunction

  task automatic checkPixel(input line_vec_t v, input int k, input string tag);
    string p;
    p = $sformatf("%s px%0d", tag, k);
    checkOutput({p, " valid"}, pix_valid, 1);
    checkOutput({p, " x"}, pix_x, exp_x[v.base + k]);
    checkOutput({p, " y"}, pix_y, exp_y[v.base + k]);
    checkOutput({p, " last"}, pix_last, (k == v.npix - 1) ? 1 : 0);
    if (k == 0) begin
      checkOutput({p, " attr"}, pix_attr, v.attr);
      checkOutput({p, " octant"}, line_octant, v.oct);
    end
  endtask

  // Accept at cycle N, SETUP at N+1, first pixel at N+2, one pixel per cycle
  task automatic applyStimulus(input line_vec_t v, input string tag);
    @(negedge clk);
    checkOutput({tag, " ready_idle"}, line_ready, 1);
    line_cap_reg = {v.x0, v.y0, v.x1, v.y1, v.attr};
    line_valid   = 1'b1;
    @(negedge clk);
    line_valid = 1'b0;
    checkOutput({tag, " ready_setup"}, line_ready, 0);
    checkOutput({tag, " busy_setup"}, busy, 1);
    checkOutput({tag, " valid_setup"}, pix_valid, 0);
    @(negedge clk);
    for (int k = 0; k < v.npix; k++) begin
      if (k == v.stall_at) begin
        pix_ready = 1'b0;
        repeat (3) begin
          checkPixel(v, k, {tag, " stall"});
          @(negedge clk);
        end
        pix_ready = 1'b1;
      end
      checkPixel(v, k, tag);
      if (k != v.npix - 1) checkOutput({tag, " ready_draw"}, line_ready, 0);
      @(negedge clk);
    end
    checkOutput({tag, " ready_after"}, line_ready, 1);
    checkOutput({tag, " valid_after"}, pix_valid, 0);
    checkOutput({tag, " busy_after"}, busy, 0);
  endtask

  initial begin
    rst          = 1'b1;
    line_valid   = 1'b0;
    pix_ready    = 1'b1;
    line_cap_reg = '0;

    addLine(0, 0, 3, 0, 6'h2A, 2'b01, -1);
    addPix(0, 0); addPix(1, 0); addPix(2, 0); addPix(3, 0);
    addLine(5, 5, 3, 9, 6'h15, 2'b11, -1);
    addPix(5, 5); addPix(5, 6); addPix(4, 7); addPix(4, 8); addPix(3, 9);
    addLine(0, 0, 2, 2, 6'h01, 2'b01, -1);
    addPix(0, 0); addPix(1, 1); addPix(2, 2);
    addLine(7, 7, 7, 7, 6'h3F, 2'b01, -1);
    addPix(7, 7);
    addLine(3, 8, 0, 7, 6'h07, 2'b01, -1);
    addPix(3, 8); addPix(2, 8); addPix(1, 7); addPix(0, 7);
    addLine(2, 0, 3, 4, 6'h11, 2'b00, -1);
    addPix(2, 0); addPix(2, 1); addPix(2, 2); addPix(3, 3); addPix(3, 4);
    addLine(4, 1, 0, 2, 6'h22, 2'b10, -1);
    addPix(4, 1); addPix(3, 1); addPix(2, 1); addPix(1, 2); addPix(0, 2);
    addLine(0, 0, 5, 2, 6'h0C, 2'b01, 2);
    addPix(0, 0); addPix(1, 0); addPix(2, 1); addPix(3, 1); addPix(4, 2); addPix(5, 2);
    addLine(1023, 0, 0, 0, 6'h33, 2'b10, -1);
    for (int i = 1023; i >= 0; i--) addPix(i, 0);
    addLine(0, 0, 1, 0, 6'h05, 2'b01, -1);
    addPix(0, 0); addPix(1, 0);

    repeat (2) @(negedge clk);
    checkOutput("reset pix_valid", pix_valid, 0);
    checkOutput("reset pix_x", pix_x, 0);
    checkOutput("reset pix_y", pix_y, 0);
    checkOutput("reset pix_attr", pix_attr, 0);
    checkOutput("reset pix_last", pix_last, 0);
    checkOutput("reset octant", line_octant, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset line_ready", line_ready, 1);
    rst = 1'b0;

    for (int i = 0; i < lines.size() - 1; i++) begin
      applyStimulus(lines[i], $sformatf("line%0d", i));
    end

    // Drop a line partway through DRAW with an asynchronous reset
    @(negedge clk);
    line_cap_reg = {10'd0, 10'd0, 10'd5, 10'd2, 6'h0C};
    line_valid   = 1'b1;
    @(negedge clk);
    line_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midreset pre valid", pix_valid, 1);
    checkOutput("midreset pre x", pix_x, 2);
    rst = 1'b1;
    #1;
    checkOutput("midreset valid", pix_valid, 0);
    checkOutput("midreset last", pix_last, 0);
    checkOutput("midreset busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset ready", line_ready, 1);
    applyStimulus(lines[lines.size() - 1], "post_reset");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
